// File: rtl/core_task_dispatcher.sv
// Task dispatcher: pairs incoming task addresses with free core IDs popped from the
// free-core queue, issues held start requests and returns finished cores to the queue.
module core_task_dispatcher #(
    parameter int unsigned CORES  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       task_valid,
    input  logic [ADDR_W-1:0]          task_addr,
    output logic                       task_ready,
    input  logic [$clog2(CORES)-1:0]   current_id,
    input  logic                       current_valid,
    output logic                       current_consume,
    output logic [$clog2(CORES)-1:0]   enqueue_id,
    output logic                       enqueue_valid,
    output logic [CORES-1:0]           core_start,
    output logic [ADDR_W-1:0]          core_start_addr,
    input  logic [CORES-1:0]           core_start_ack,
    input  logic [CORES-1:0]           core_done,
    output logic [CORES-1:0]           busy,
    output logic                       init_done
);

    localparam int unsigned IDW    = $clog2(CORES);
    localparam int unsigned SEED_W = $clog2(CORES + 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_START = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic [CORES-1:0]    busy_q, busy_d;
    logic [CORES-1:0]    pend_q, pend_d;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CORES-1:0]    start_q, start_d;
    logic                task_ready_q, task_ready_d;
    logic                consume_q, consume_d;
    logic                enq_valid_q, enq_valid_d;
    logic [IDW-1:0]      enq_id_q, enq_id_d;
    logic                init_done_q, init_done_d;

    logic                pick_vld;
    logic [IDW-1:0]      pick_id;
    logic                dispatch;

    assign dispatch = task_valid && current_valid;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (seed_q == SEED_W'(CORES)) state_d = S_IDLE;
            S_IDLE:  if (dispatch) state_d = S_START;
            S_START: if (core_start_ack[id_q]) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Round-robin search of pending dones, starting at the rr pointer
    always_comb begin
        int unsigned idx;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int unsigned k = 0; k < CORES; k++) begin
            idx = (32'(rr_q) + k) % CORES;
            if (!pick_vld && pend_q[idx]) begin
                pick_vld = 1'b1;
                pick_id  = IDW'(idx);
            end
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        seed_d       = seed_q;
        busy_d       = busy_q;
        pend_d       = pend_q;
        rr_d         = rr_q;
        id_d         = id_q;
        addr_d       = addr_q;
        start_d      = start_q;
        task_ready_d = 1'b0;
        consume_d    = 1'b0;
        enq_valid_d  = 1'b0;
        enq_id_d     = enq_id_q;
        init_done_d  = init_done_q;

        if (state_q != S_INIT) begin
            if (pick_vld) begin
                enq_valid_d     = 1'b1;
                enq_id_d        = pick_id;
                pend_d[pick_id] = 1'b0;
                busy_d[pick_id] = 1'b0;
                rr_d            = (pick_id == IDW'(CORES - 1)) ? '0 : pick_id + IDW'(1);
            end
            // A fresh done outranks the clear of its own push
            pend_d = pend_d | (core_done & busy_q);
        end

        case (state_q)
            S_INIT: begin
                if (seed_q != SEED_W'(CORES)) begin
                    enq_valid_d = 1'b1;
                    enq_id_d    = IDW'(seed_q);
                    seed_d      = seed_q + SEED_W'(1);
                end else begin
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (dispatch) begin
                    task_ready_d = 1'b1;
                    consume_d    = 1'b1;
                    id_d         = current_id;
                    addr_d       = task_addr;
                    start_d      = CORES'(1) << current_id;
                end
            end
            S_START: begin
                if (core_start_ack[id_q]) begin
                    start_d      = '0;
                    busy_d[id_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seed_q       <= '0;
            busy_q       <= '0;
            pend_q       <= '0;
            rr_q         <= '0;
            id_q         <= '0;
            addr_q       <= '0;
            start_q      <= '0;
            task_ready_q <= 1'b0;
            consume_q    <= 1'b0;
            enq_valid_q  <= 1'b0;
            enq_id_q     <= '0;
            init_done_q  <= 1'b0;
        end else begin
            seed_q       <= seed_d;
            busy_q       <= busy_d;
            pend_q       <= pend_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            start_q      <= start_d;
            task_ready_q <= task_ready_d;
            consume_q    <= consume_d;
            enq_valid_q  <= enq_valid_d;
            enq_id_q     <= enq_id_d;
            init_done_q  <= init_done_d;
        end
    end

    assign task_ready      = task_ready_q;
    assign current_consume = consume_q;
    assign enqueue_id      = enq_id_q;
    assign enqueue_valid   = enq_valid_q;
    assign core_start      = start_q;
    assign core_start_addr = addr_q;
    assign busy            = busy_q;
    assign init_done       = init_done_q;

endmodule

// File: tb/tb_core_task_dispatcher.sv
// Directed bench for core_task_dispatcher with a behavioural free-core FIFO attached.
module tb_core_task_dispatcher;

    localparam int unsigned CORES  = 4;
    localparam int unsigned ADDR_W = 32;

    logic              clk;
    logic              reset_n;
    logic              task_valid;
    logic [31:0]       task_addr;
    logic              task_ready;
    logic [1:0]        current_id;
    logic              current_valid;
    logic              current_consume;
    logic [1:0]        enqueue_id;
    logic              enqueue_valid;
    logic [3:0]        core_start;
    logic [31:0]       core_start_addr;
    logic [3:0]        core_start_ack;
    logic [3:0]        core_done;
    logic [3:0]        busy;
    logic              init_done;

    int n_cmp  = 0;
    int n_fail = 0;

    core_task_dispatcher #(.CORES(CORES), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .task_valid      (task_valid),
        .task_addr       (task_addr),
        .task_ready      (task_ready),
        .current_id      (current_id),
        .current_valid   (current_valid),
        .current_consume (current_consume),
        .enqueue_id      (enqueue_id),
        .enqueue_valid   (enqueue_valid),
        .core_start      (core_start),
        .core_start_addr (core_start_addr),
        .core_start_ack  (core_start_ack),
        .core_done       (core_done),
        .busy            (busy),
        .init_done       (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-core queue model (push and pop in the same cycle allowed)
    logic [1:0] fmem [0:7];
    logic [2:0] frd, fwr;
    logic [3:0] fcnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frd  <= '0;
            fwr  <= '0;
            fcnt <= '0;
        end else begin
            if (enqueue_valid) begin
                fmem[fwr] <= enqueue_id;
                fwr       <= fwr + 3'd1;
            end
            if (current_consume && fcnt != 4'd0) frd <= frd + 3'd1;
            fcnt <= fcnt + 4'(enqueue_valid) - 4'(current_consume && fcnt != 4'd0);
        end
    end

    assign current_id    = fmem[frd];
    assign current_valid = (fcnt != 4'd0);

    task automatic test_reset;
        task_valid     = 1'b0;
        task_addr      = '0;
        core_start_ack = '0;
        core_done      = '0;
        reset_n        = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (task_ready !== 1'b0 || current_consume !== 1'b0 || enqueue_valid !== 1'b0 ||
            init_done !== 1'b0 || core_start !== 4'b0 || busy !== 4'b0 ||
            enqueue_id !== 2'b0 || core_start_addr !== 32'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b cons=%b enq=%b/%0d init=%b start=%b busy=%b addr=%h, want all zero",
                     task_ready, current_consume, enqueue_valid, enqueue_id, init_done, core_start, busy, core_start_addr);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (enqueue_valid !== 1'b1 || enqueue_id !== 2'(i) || init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL seed_push[%0d]: got valid=%b id=%0d init_done=%b, want valid=1 id=%0d init_done=0",
                         i, enqueue_valid, enqueue_id, init_done, i);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (init_done !== 1'b1 || enqueue_valid !== 1'b0 || busy !== 4'b0) begin
            n_fail++;
            $display("FAIL init_done: got init_done=%b enq=%b busy=%b, want 1 0 0000", init_done, enqueue_valid, busy);
        end
    endtask

    // Offer one task, expect it on core exp_id; optionally acknowledge after 'hold' cycles
    task automatic dispatch(input logic [31:0] addr, input int exp_id, input int hold,
                            input bit do_ack, input bit keep_valid, input logic [31:0] next_addr);
        logic [3:0] oh;
        bit seen;
        oh         = 4'(1) << exp_id;
        seen       = 1'b0;
        task_valid = 1'b1;
        task_addr  = addr;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (task_ready === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL accept_wait addr=%h: task_ready got 0 for 30 cycles, want 1", addr);
            task_valid = 1'b0;
            return;
        end
        n_cmp++;
        if (current_consume !== 1'b1 || core_start !== oh || core_start_addr !== addr) begin
            n_fail++;
            $display("FAIL accept addr=%h: got consume=%b start=%b saddr=%h, want 1 %b %h",
                     addr, current_consume, core_start, core_start_addr, oh, addr);
        end
        if (keep_valid) task_addr = next_addr;
        else            task_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_cmp++;
            if (core_start !== oh || core_start_addr !== addr || task_ready !== 1'b0 || current_consume !== 1'b0) begin
                n_fail++;
                $display("FAIL start_hold[%0d] addr=%h: got start=%b saddr=%h rdy=%b cons=%b, want %b %h 0 0",
                         h, addr, core_start, core_start_addr, task_ready, current_consume, oh, addr);
            end
            core_start_ack = ~oh;
        end
        if (do_ack) begin
            core_start_ack = oh;
            @(negedge clk);
            core_start_ack = '0;
            n_cmp++;
            if (core_start !== 4'b0 || busy[exp_id] !== 1'b1) begin
                n_fail++;
                $display("FAIL ack_release core %0d: got start=%b busy=%b, want 0000 busy[%0d]=1",
                         exp_id, core_start, busy, exp_id);
            end
        end else begin
            core_start_ack = '0;
        end
    endtask

    task automatic test_single;
        dispatch(32'h100, 0, 3, 1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (busy !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_busy: got %b, want 0001", busy);
        end
    endtask

    task automatic test_back_to_back;
        dispatch(32'h100, 0, 2, 1'b1, 1'b1, 32'h200);
        dispatch(32'h200, 1, 2, 1'b1, 1'b1, 32'h300);
        dispatch(32'h300, 2, 2, 1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (busy !== 4'b0111) begin
            n_fail++;
            $display("FAIL b2b_busy: got %b, want 0111", busy);
        end
    endtask

    task automatic test_done_rr;
        logic [1:0] exp_ids [0:1];
        exp_ids[0] = 2'd1;
        exp_ids[1] = 2'd2;
        core_done = 4'b0110;
        @(negedge clk);
        core_done = 4'b0000;
        n_cmp++;
        if (enqueue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_latency: got enqueue_valid=%b, want 0", enqueue_valid);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (enqueue_valid !== 1'b1 || enqueue_id !== exp_ids[i]) begin
                n_fail++;
                $display("FAIL done_push[%0d]: got valid=%b id=%0d, want 1 %0d", i, enqueue_valid, enqueue_id, exp_ids[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (enqueue_valid !== 1'b0 || busy !== 4'b0001) begin
            n_fail++;
            $display("FAIL done_after: got enq=%b busy=%b, want 0 0001", enqueue_valid, busy);
        end
    endtask

    task automatic test_ignored_done;
        core_done = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            core_done = 4'b0000;
            n_cmp++;
            if (enqueue_valid !== 1'b0 || busy !== 4'b0001) begin
                n_fail++;
                $display("FAIL ignored_done[%0d]: got enq=%b busy=%b, want 0 0001", i, enqueue_valid, busy);
            end
        end
    endtask

    task automatic test_queue_empty;
        // Drain the queue (holds 3,1,2 at this point)
        dispatch(32'h400, 3, 0, 1'b1, 1'b0, 32'h0);
        dispatch(32'h500, 1, 0, 1'b1, 1'b0, 32'h0);
        dispatch(32'h600, 2, 0, 1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (busy !== 4'b1111) begin
            n_fail++;
            $display("FAIL all_busy: got %b, want 1111", busy);
        end
        task_valid = 1'b1;
        task_addr  = 32'h700;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (task_ready !== 1'b0 || current_consume !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_stall[%0d]: got rdy=%b cons=%b, want 0 0", i, task_ready, current_consume);
            end
        end
        core_done = 4'b0100;
        @(negedge clk);
        core_done = 4'b0000;
        dispatch(32'h700, 2, 2, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (busy !== 4'b1011 || core_start !== 4'b0100) begin
            n_fail++;
            $display("FAIL refill_dispatch: got busy=%b start=%b, want 1011 0100", busy, core_start);
        end
    endtask

    task automatic test_reset_mid_start;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (core_start !== 4'b0 || busy !== 4'b0 || core_start_addr !== 32'b0) begin
            n_fail++;
            $display("FAIL async_reset: got start=%b busy=%b saddr=%h, want 0000 0000 0",
                     core_start, busy, core_start_addr);
        end
        test_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, want finished");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        task_valid     = 1'b0;
        task_addr      = '0;
        core_start_ack = '0;
        core_done      = '0;
        test_reset();
        test_single();
        test_reset();
        test_back_to_back();
        test_done_rr();
        test_ignored_done();
        test_queue_empty();
        test_reset_mid_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/core_task_dispatcher.md
Name: core_task_dispatcher

Overview:
- Consumer and producer partner of core_simple_queue, the free-core FIFO of core IDs.
- Pops the head free-core ID (current_id/current_valid/current_consume) and pairs it with an incoming task start address.
- Issues a held start request to that core and tracks which cores are busy.
- When a core signals done, pushes its ID back into the queue (enqueue_id/enqueue_valid).
- After reset, seeds the queue with every core ID.

Parameters:
- CORES, 4, number of worker cores; must be >= 2.
- ADDR_W, 32, width of the task start address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- task_valid  input  1  task request pending.
- task_addr  input  ADDR_W  task start address; must be stable while task_valid=1 and task_ready=0.
- task_ready  output  1  one-cycle accept pulse; task_valid&&task_ready means the task is consumed.
- current_id  input  $clog2(CORES)  head of the free-core queue.
- current_valid  input  1  queue non-empty.
- current_consume  output  1  one-cycle pop pulse to the queue.
- enqueue_id  output  $clog2(CORES)  core ID pushed to the queue.
- enqueue_valid  output  1  one-cycle push strobe.
- core_start  output  CORES  one-hot start request; held until acknowledged.
- core_start_addr  output  ADDR_W  start address for the core selected by core_start.
- core_start_ack  input  CORES  start accepted, per core.
- core_done  input  CORES  one-cycle completion pulse, per core.
- busy  output  CORES  per-core busy flags.
- init_done  output  1  high once seeding of the queue is complete.

Behaviour:
- Outputs are registered.
- Reset (reset_n=0, asynchronous):
  - state=INIT, seed counter=0, busy=0, done_pending=0, rr pointer=0.
  - All outputs 0, including enqueue_id and core_start_addr.
  - Reset mid-operation abandons any outstanding start and all pending dones; seeding replays from ID 0.
- INIT:
  - One push per cycle: enqueue_valid=1 with enqueue_id=0,1,...,CORES-1 on consecutive cycles.
  - The cycle after the last push: init_done=1, state=IDLE.
  - No dispatch occurs during INIT.
- IDLE:
  - When task_valid && current_valid: latch task_addr and current_id, and assert task_ready=1 and current_consume=1 for exactly one cycle. Next state is START.
  - Otherwise remain in IDLE with both pulses 0.
- START:
  - core_start[id]=1 and core_start_addr=latched address, held until core_start_ack[id]=1 is sampled. Acks from other cores are ignored.
  - On that edge: core_start=0, busy[id]=1, state=IDLE.
  - Next dispatch is possible no earlier than the cycle after returning to IDLE. This gives the queue one cycle to advance its head after the pop.
- Done path (runs concurrently with IDLE/START, never in INIT):
  - core_done[i] with busy[i]=1 sets done_pending[i].
  - core_done[i] with busy[i]=0 is ignored.
  - Each cycle, if done_pending != 0: round-robin pick starting from rr pointer. Issue enqueue_valid=1, enqueue_id=pick for one cycle; clear done_pending[pick] and busy[pick]; set rr = pick+1 (mod CORES).
  - Throughput is one push per cycle. Simultaneous dones from k cores produce k pushes on k consecutive cycles, in round-robin order.
  - core_done[i] arriving in the same cycle as its own push: the set wins. This is legal only if the core has been re-dispatched; otherwise busy is already clear and the done is ignored.
- Dispatch and push may occur in the same cycle, since the queue accepts push and pop together.
- The block never pops when current_valid=0 and never pushes more than CORES IDs outstanding. With no illegal dones, the queue cannot overflow.
- current_id is not validated: it is assumed not busy by the protocol. An ID that is already busy is still dispatched (implementation-visible bug only).

Test Plan:
- Reset release, CORES=4 -> enqueue_valid on 4 consecutive cycles with IDs 0,1,2,3; init_done=1 the following cycle; busy=0.
- task_valid=1, task_addr=0x100, queue head 0 -> task_ready and current_consume pulse once; core_start=4'b0001 with addr 0x100 held until ack after 3 cycles; then busy=4'b0001.
- Three back-to-back tasks 0x100/0x200/0x300 while holding acks -> cores 0,1,2 started in order; no second task_ready before each ack; busy=4'b0111.
- core_done=4'b0110 in one cycle with rr=0 -> pushes ID 1 then ID 2 on consecutive cycles; busy=4'b0001.
- core_done[3] while busy[3]=0 -> no enqueue_valid; busy unchanged.
- Queue empty (current_valid=0) with task_valid=1 for 10 cycles -> task_ready stays 0; a core_done then refills the queue, and the task dispatches to that ID. Assert reset_n=0 mid-START -> core_start=0 immediately; INIT reseeds IDs 0..3.
